// File: rtl/wavegen_sequencer_if.sv
// AHB-Lite slave-side bus bundle for the wgen pulse sequencer.
// master drives the request; slave returns ready, data and response.
interface wavegen_sequencer_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE,
    output HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE,
    input  HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/wavegen_sequencer.sv
// Autonomous wgen pulse-train generator on AHB-Lite.
// Software sets HIGH/LOW/NPULSE and starts; irq on finite completion.
module wavegen_sequencer #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 16
) (
  input  logic HCLK,
  input  logic HRESET,
  wavegen_sequencer_if.slave bus,
  output logic wgen,
  output logic irq
);

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } state_t;

  state_t state_q, state_d;

  logic             act_q;
  logic             wr_q;
  logic [2:0]       addr_q;

  logic             cont_q, cont_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [NP_W-1:0]  np_q, np_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NP_W-1:0]  rem_q, rem_d;
  logic             wgen_d;
  logic             done_q, done_d;
  logic             irq_d;

  logic             wr_en;
  logic             sel_ctrl, sel_high, sel_low;
  logic             sel_np, sel_stat;
  logic             start_w, stop_w;
  logic             busy;
  logic [CNT_W-1:0] hi_load, lo_load;
  logic [31:0]      stat_w;
  logic             unused_ok;

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  assign unused_ok = ^{bus.HSIZE, bus.HPROT,
                       bus.HADDR, bus.HTRANS,
                       bus.HWDATA};

  assign sel_ctrl = (addr_q == 3'd0);
  assign sel_high = (addr_q == 3'd1);
  assign sel_low  = (addr_q == 3'd2);
  assign sel_np   = (addr_q == 3'd3);
  assign sel_stat = (addr_q == 3'd4);

  assign wr_en   = act_q & wr_q & bus.HREADY;
  assign start_w = wr_en & sel_ctrl & bus.HWDATA[0];
  assign stop_w  = wr_en & sel_ctrl & bus.HWDATA[2];
  assign busy    = (state_q != IDLE);

  // a zero duration still lasts one cycle
  assign hi_load = (high_q == '0) ? '0
                 : high_q - CNT_W'(1);
  assign lo_load = (low_q == '0) ? '0
                 : low_q - CNT_W'(1);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else if (bus.HREADY) begin
      act_q  <= bus.HSEL & bus.HTRANS[1];
      wr_q   <= bus.HWRITE;
      addr_q <= bus.HADDR[4:2];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      np_q     <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      wgen     <= 1'b0;
      done_q   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      cont_q   <= cont_d;
      irq_en_q <= irq_en_d;
      high_q   <= high_d;
      low_q    <= low_d;
      np_q     <= np_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      wgen     <= wgen_d;
      done_q   <= done_d;
      irq      <= irq_d;
    end
  end

  always_comb begin
    cont_d   = cont_q;
    irq_en_d = irq_en_q;
    high_d   = high_q;
    low_d    = low_q;
    np_d     = np_q;
    if (wr_en) begin
      unique case (1'b1)
        sel_ctrl: begin
          cont_d   = bus.HWDATA[1];
          irq_en_d = bus.HWDATA[3];
        end
        sel_high: high_d = bus.HWDATA[CNT_W-1:0];
        sel_low:  low_d  = bus.HWDATA[CNT_W-1:0];
        sel_np:   np_d   = bus.HWDATA[NP_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wgen_d  = wgen;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    done_d  = done_q;

    if (wr_en & sel_stat & bus.HWDATA[1]) begin
      done_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_w && !stop_w &&
            (cont_d || np_q != '0)) begin
          state_d = HI;
          wgen_d  = 1'b1;
          cnt_d   = hi_load;
          rem_d   = np_q;
          done_d  = 1'b0;
        end
      end
      HI: begin
        if (cnt_q == '0) begin
          state_d = LO;
          wgen_d  = 1'b0;
          cnt_d   = lo_load;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LO: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (cont_q) begin
          state_d = HI;
          wgen_d  = 1'b1;
          cnt_d   = hi_load;
        end else if (rem_q <= NP_W'(1)) begin
          // rem==0 here only if CONT was cleared
          state_d = IDLE;
          rem_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = HI;
          wgen_d  = 1'b1;
          cnt_d   = hi_load;
          rem_d   = rem_q - NP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wgen_d  = 1'b0;
      end
    endcase

    if (stop_w) begin
      state_d = IDLE;
      wgen_d  = 1'b0;
      cnt_d   = '0;
      rem_d   = '0;
    end

    irq_d = done_d & irq_en_d;
  end

  always_comb begin
    stat_w            = '0;
    stat_w[0]         = busy;
    stat_w[1]         = done_q;
    stat_w[16 +: NP_W] = rem_q;
  end

  always_comb begin
    bus.HRDATA = '0;
    unique case (1'b1)
      sel_ctrl: bus.HRDATA = {28'd0, irq_en_q,
                              1'b0, cont_q, 1'b0};
      sel_high: bus.HRDATA = 32'(high_q);
      sel_low:  bus.HRDATA = 32'(low_q);
      sel_np:   bus.HRDATA = 32'(np_q);
      sel_stat: bus.HRDATA = stat_w;
      default:  bus.HRDATA = '0;
    endcase
  end

endmodule
